// File: rtl/spi_controller.sv
// Mode-0 SPI master: one byte per SETUP/XFER pass, MSB first, registered pins.
// Define SPI_CONTROLLER_BURST_EN to keep ss low across bytes until tx_last (HOLD state).
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       ss,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    GAP   = 3'd3
`ifdef SPI_CONTROLLER_BURST_EN
    , HOLD = 3'd4
`endif
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_div;
  logic [6:0]  r_tx;
  logic [7:0]  r_rx;
  logic [7:0]  r_rx_data;
  logic [4:0]  r_edge;
  logic        r_ss, r_sck, r_mosi, r_rx_valid;
  logic        w_tick, w_accept, w_done, w_last, w_rdy_st;

`ifdef SPI_CONTROLLER_BURST_EN
  logic r_last;
  assign w_last   = r_last;
  assign w_rdy_st = (r_state == IDLE) || (r_state == HOLD);
`else
  logic w_unused_last;
  assign w_unused_last = tx_last;
  assign w_last   = 1'b1;
  assign w_rdy_st = (r_state == IDLE);
`endif

  assign w_tick   = (r_div == DIV_M1);
  assign tx_ready = !rst && w_rdy_st;
  assign w_accept = tx_valid && tx_ready;
  // r_edge counts sck edges already driven; the 17th tick closes the trailing low half-period
  assign w_done   = (r_state == XFER) && w_tick && (r_edge == 5'd16);

  assign busy     = !rst && (r_state != IDLE);
  assign ss       = r_ss;
  assign sck      = r_sck;
  assign mosi     = r_mosi;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_nxt = SETUP;
      SETUP: if (w_tick)   w_state_nxt = XFER;
      XFER:  if (w_done) begin
`ifdef SPI_CONTROLLER_BURST_EN
        w_state_nxt = w_last ? GAP : HOLD;
`else
        w_state_nxt = w_last ? GAP : GAP;
`endif
      end
`ifdef SPI_CONTROLLER_BURST_EN
      HOLD:  if (w_accept) w_state_nxt = SETUP;
`endif
      GAP:   if (w_tick)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= 8'd0;
      r_tx       <= 7'd0;
      r_rx       <= 8'd0;
      r_rx_data  <= 8'd0;
      r_edge     <= 5'd0;
      r_ss       <= 1'b1;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
`ifdef SPI_CONTROLLER_BURST_EN
      r_last     <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
      r_div      <= (w_tick || (w_state_nxt != r_state)) ? 8'd0 : r_div + 8'd1;
      if (w_accept) begin
        r_ss   <= 1'b0;
        r_mosi <= tx_data[7];
        r_tx   <= tx_data[6:0];
`ifdef SPI_CONTROLLER_BURST_EN
        r_last <= tx_last;
`endif
      end
      if (r_state == SETUP && w_tick) begin
        r_sck  <= 1'b1;
        r_rx   <= {r_rx[6:0], miso};
        r_edge <= 5'd1;
      end
      if (r_state == XFER && w_tick) begin
        if (r_edge == 5'd16) begin
          r_rx_data  <= r_rx;
          r_rx_valid <= 1'b1;
          if (w_state_nxt == GAP) begin
            r_ss   <= 1'b1;
            r_mosi <= 1'b0;
          end
        end else if (r_sck) begin
          r_sck  <= 1'b0;
          r_edge <= r_edge + 5'd1;
          // the 8th falling edge leaves the last bit on the line
          if (r_edge != 5'd15) begin
            r_mosi <= r_tx[6];
            r_tx   <= {r_tx[5:0], 1'b0};
          end
        end else begin
          r_sck  <= 1'b1;
          r_rx   <= {r_rx[6:0], miso};
          r_edge <= r_edge + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench: CLK_DIV=4 instance for byte/burst/reset/stability cases, CLK_DIV=1 instance for held tx_valid.
module tb_spi_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, tx_last = 1'b0;
  logic       tx_ready, rx_valid, busy, ss, sck, mosi, miso;
  logic [7:0] rx_data;

  logic [7:0] tx_data1 = 8'h00;
  logic       tx_valid1 = 1'b0, tx_last1 = 1'b0;
  logic       tx_ready1, rx_valid1, busy1, ss1, sck1, mosi1;
  logic [7:0] rx_data1;

  spi_controller #(.CLK_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .ss(ss), .sck(sck), .mosi(mosi), .miso(miso));

  spi_controller #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_last(tx_last1),
    .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
    .ss(ss1), .sck(sck1), .mosi(mosi1), .miso(mosi1));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // peripheral / monitor for the CLK_DIV=4 instance
  logic       loop = 1'b1;
  logic [7:0] p_sh = 8'h00;
  int         p_cnt = 0;
  logic [7:0] resp_q[$];
  logic       mosi_q[$];
  logic [7:0] rx_q[$];
  int         ss_len_q[$], gap_q[$];
  int         ss_cnt = 0, gap_cnt = 0;
  logic       p_sck = 1'b0, p_ss = 1'b1;

  assign miso = loop ? mosi : p_sh[7];

  always @(negedge clk) begin
    if (rst) begin
      p_cnt = 0; ss_cnt = 0; gap_cnt = 0;
    end else begin
      if (sck && !p_sck) mosi_q.push_back(mosi);
      if (!sck && p_sck) begin
        if (p_cnt == 7) begin
          p_cnt = 0;
          p_sh = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
        end else begin
          p_sh = {p_sh[6:0], 1'b0};
          p_cnt++;
        end
      end
      if (rx_valid) rx_q.push_back(rx_data);
      if (!ss) ss_cnt++;
      else if (!p_ss) begin ss_len_q.push_back(ss_cnt); ss_cnt = 0; end
      if (busy && ss) gap_cnt++;
      else if (gap_cnt != 0) begin gap_q.push_back(gap_cnt); gap_cnt = 0; end
    end
    p_sck = sck;
    p_ss  = ss;
  end

  // monitor for the CLK_DIV=1 instance
  int   cyc = 0, acc1 = 0, falls1 = 0, rises1 = 0, rx1 = 0, bad_rdy1 = 0, bad_per1 = 0, last_rise1 = -1;
  logic p_sck1 = 1'b0, p_ss1 = 1'b1;
  always @(posedge clk) begin
    cyc++;
    if (!rst && tx_valid1 && tx_ready1) acc1++;
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (!ss1 && p_ss1) falls1++;
      if (ss1) last_rise1 = -1;
      if (!ss1 && tx_ready1) bad_rdy1++;
      if (!ss1 && sck1 && !p_sck1) begin
        if (last_rise1 >= 0 && (cyc - last_rise1) != 2) bad_per1++;
        last_rise1 = cyc;
        rises1++;
      end
      if (rx_valid1) begin
        rx1++;
        if (rx_data1 !== 8'h81) bad_per1 += 1000;
      end
    end
    p_sck1 = sck1;
    p_ss1  = ss1;
  end

  function automatic logic [31:0] mbyte(input int i);
    logic [7:0] b;
    if (mosi_q.size() < (i + 1) * 8) return 32'hFFFF_FFFF;
    for (int k = 0; k < 8; k++) b[7-k] = mosi_q[i*8+k];
    return {24'd0, b};
  endfunction

  function automatic logic [31:0] rxb(input int i);
    if (rx_q.size() <= i) return 32'hFFFF_FFFF;
    return {24'd0, rx_q[i]};
  endfunction

  task automatic clear_mon();
    mosi_q.delete(); rx_q.delete(); ss_len_q.delete(); gap_q.delete(); resp_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 500) begin @(negedge clk); n++; end
    chk("rdy_wait", {31'd0, tx_ready}, 1);
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 1000) begin @(negedge clk); n++; end
    chk("idle_wait", {31'd0, busy}, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ss",       {31'd0, ss}, 1);
    chk("rst_sck",      {31'd0, sck}, 0);
    chk("rst_mosi",     {31'd0, mosi}, 0);
    chk("rst_rx_data",  {24'd0, rx_data}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_busy",     {31'd0, busy}, 0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", {31'd0, tx_ready}, 1);

    // single byte, loopback
    clear_mon(); loop = 1'b1;
    send(8'hA5, 1'b1);
    wait_idle();
    chk("a5_mosi",   mbyte(0), 32'hA5);
    chk("a5_rx",     rxb(0), 32'hA5);
    chk("a5_rx_cnt", rx_q.size(), 1);
    chk("a5_ss_len", (ss_len_q.size() == 1 && ss_len_q[0] >= 67 && ss_len_q[0] <= 69) ? 1 : 0, 1);
    chk("a5_gap",    (gap_q.size() == 1) ? gap_q[0] : -1, 4);
    chk("idle_mosi", {31'd0, mosi}, 0);
    chk("idle_ss",   {31'd0, ss}, 1);

    // two bytes, peripheral returns 0x11, 0x22
    clear_mon(); loop = 1'b0; p_sh = 8'h11; resp_q.push_back(8'h22);
    send(8'h3C, 1'b0);
    send(8'hC3, 1'b1);
    wait_idle();
    chk("b_mosi0",  mbyte(0), 32'h3C);
    chk("b_mosi1",  mbyte(1), 32'hC3);
    chk("b_rx0",    rxb(0), 32'h11);
    chk("b_rx1",    rxb(1), 32'h22);
    chk("b_rx_cnt", rx_q.size(), 2);
`ifdef SPI_CONTROLLER_BURST_EN
    chk("b_ss_rises", ss_len_q.size(), 1);
    chk("b_gaps",     gap_q.size(), 1);
`else
    chk("b_ss_rises", ss_len_q.size(), 2);
    chk("b_gaps",     gap_q.size(), 2);
    for (int i = 0; i < gap_q.size(); i++) chk("b_gap_min", (gap_q[i] >= 4) ? 1 : 0, 1);
`endif

    // reset mid-byte, then a clean byte
    clear_mon(); loop = 1'b1;
    send(8'hFF, 1'b1);
    begin
      int n = 0;
      while (mosi_q.size() < 5 && n < 200) begin @(negedge clk); n++; end
      chk("abort_reach_bit3", (mosi_q.size() >= 5) ? 1 : 0, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ss",    {31'd0, ss}, 1);
    chk("abort_sck",   {31'd0, sck}, 0);
    chk("abort_mosi",  {31'd0, mosi}, 0);
    chk("abort_busy",  {31'd0, busy}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_no_rx", rx_q.size(), 0);
    clear_mon();
    send(8'h0F, 1'b1);
    wait_idle();
    chk("post_mosi", mbyte(0), 32'h0F);
    chk("post_rx",   rxb(0), 32'h0F);
    chk("post_cnt",  rx_q.size(), 1);

    // inputs change after acceptance
    clear_mon();
    send(8'hF0, 1'b1);
    tx_last = 1'b0;
    repeat (20) @(negedge clk);
    tx_data = 8'h00;
    wait_idle();
    chk("hold_mosi", mbyte(0), 32'hF0);
    chk("hold_rx",   rxb(0), 32'hF0);
    chk("hold_ss",   ss_len_q.size(), 1);

    // CLK_DIV=1, tx_valid held high
    tx_data1 = 8'h81; tx_last1 = 1'b1; tx_valid1 = 1'b1;
    repeat (60) @(negedge clk);
    tx_valid1 = 1'b0;
    begin
      int n = 0;
      @(negedge clk);
      while (busy1 && n < 200) begin @(negedge clk); n++; end
      chk("d1_idle_wait", {31'd0, busy1}, 0);
    end
    chk("d1_multi",     (acc1 >= 2) ? 1 : 0, 1);
    chk("d1_acc_per_ss", acc1, falls1);
    chk("d1_rises",     rises1, 8 * acc1);
    chk("d1_rx_cnt",    rx1, acc1);
    chk("d1_period",    bad_per1, 0);
    chk("d1_rdy_low",   bad_rdy1, 0);
    chk("d1_rx_data",   {24'd0, rx_data1}, 32'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4, giving the SCK half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port tx_data  input  8  byte to transmit, MSB first.
REQ-005 SHALL have port tx_valid  input  1  tx_data valid.
REQ-006 SHALL have port tx_last  input  1  byte ends the transaction; sampled with tx_data.
REQ-007 SHALL have port tx_ready  output  1  controller accepts a byte this cycle.
REQ-008 SHALL have port rx_data  output  8  byte received on miso.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse; rx_data is valid.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port ss  output  1  slave select, active-low.
REQ-012 SHALL have port sck  output  1  serial clock, idle low (mode 0).
REQ-013 SHALL have port mosi  output  1  serial data out.
REQ-014 SHALL have port miso  input  1  serial data in.

Function
REQ-015 SHALL implement states IDLE, SETUP, XFER, HOLD, GAP.
REQ-016 IDLE: tx_ready=1, ss=1, sck=0; a byte is accepted on tx_valid&&tx_ready, latching tx_data and tx_last.
REQ-017 On acceptance from IDLE: next cycle ss=0, mosi=tx_data[7], state SETUP.
REQ-018 SETUP SHALL last CLK_DIV cycles with sck=0, then enter XFER.
REQ-019 XFER SHALL toggle sck every CLK_DIV cycles, giving 8 rising and 8 falling edges per byte.
REQ-020 miso SHALL be sampled into the receive shift register on the clk cycle that drives sck high.
REQ-021 mosi SHALL advance to the next lower bit on each sck falling edge except the 8th.
REQ-022 After the 8th falling edge: rx_data updates and rx_valid pulses for exactly 1 cycle.
REQ-023 Byte time from the ss fall to rx_valid SHALL be 17*CLK_DIV clk cycles, +-1.
REQ-024 At byte end, if the latched tx_last=1, the next state SHALL be GAP; otherwise the next state SHALL be HOLD.
REQ-025 HOLD: ss=0, sck=0, tx_ready=1; an accepted byte loads mosi=bit7 and enters SETUP without raising ss.
REQ-026 GAP: ss=1, tx_ready=0 for CLK_DIV cycles, then IDLE; this guarantees minimum ss-high time.
REQ-027 tx_ready SHALL be 0 in SETUP, XFER and GAP; tx_valid in those states is ignored, not queued.
REQ-028 tx_data/tx_last changes after acceptance SHALL NOT affect the byte in flight.
REQ-029 mosi SHALL be 0 in IDLE and GAP.

Reset
REQ-030 While rst=1: state=IDLE, ss=1, sck=0, mosi=0, rx_data=0x00, rx_valid=0, busy=0, tx_ready=0.
REQ-031 tx_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-032 Reset mid-transaction SHALL abort immediately: ss rises, no rx_valid pulse is generated, and the partial byte is discarded.

Configuration
REQ-033 Macro SPI_CONTROLLER_BURST_EN SHALL gate multi-byte transactions.
REQ-034 With SPI_CONTROLLER_BURST_EN defined: HOLD exists and behaves per REQ-024/025.
REQ-035 Without SPI_CONTROLLER_BURST_EN: tx_last is ignored, every byte is treated as last (single byte per ss assertion), and HOLD SHALL NOT be synthesised.

Verification
REQ-036 CLK_DIV=4, send 0xA5 with tx_last=1, miso loopback to mosi -> mosi serialises 1,0,1,0,0,1,0,1; rx_data=0xA5; ss low ~68 cycles; then GAP of 4 cycles.
REQ-037 Burst on: send 0x3C (tx_last=0) then 0xC3 (tx_last=1), peripheral model returns 0x11,0x22 -> two rx_valid pulses with 0x11 and 0x22; ss stays low between bytes.
REQ-038 Burst off: same stimulus as REQ-037 -> ss rises between bytes; GAP is at least 4 cycles each time.
REQ-039 Assert rst during bit 3 of 0xFF -> next cycle ss=1, sck=0, mosi=0; no rx_valid; the next 0x0F transfers correctly.
REQ-040 CLK_DIV=1, tx_valid held high with 0x81 -> sck period is 2 clk; tx_ready=0 through XFER; exactly one byte is accepted per transaction.
REQ-041 Toggle tx_data to 0x00 mid-byte after 0xF0 is accepted -> mosi still sends 0xF0.
